// File: rtl/bike_bank_loader.sv
// Streams 32-bit words into one of NUM_OF_BANKS downstream register banks.
// The target bank is cleared for one cycle, then receives BANK_SIZE words in order.
module bike_bank_loader #(
    parameter int NUM_OF_BANKS = 4,
    parameter int BANK_SIZE    = 8,
    localparam int SEL_W = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1,
    localparam int CNT_W = (BANK_SIZE > 1) ? $clog2(BANK_SIZE) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SEL_W-1:0]        bank_sel,
    input  logic                    s_valid,
    input  logic [31:0]             s_data,
    output logic                    s_ready,
    output logic                    bank_resetn [NUM_OF_BANKS-1:0],
    output logic [BANK_SIZE-1:0]    bank_enable [NUM_OF_BANKS-1:0],
    output logic [31:0]             bank_din    [NUM_OF_BANKS-1:0],
    output logic                    busy,
    output logic                    done,
    output logic [NUM_OF_BANKS-1:0] bank_full
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [SEL_W:0]     NUM_BANKS_W = (SEL_W + 1)'(NUM_OF_BANKS);
    localparam logic [CNT_W-1:0]   LAST_WORD   = CNT_W'(BANK_SIZE - 1);
    localparam logic [BANK_SIZE-1:0] ONE_HOT0  = BANK_SIZE'(1);

    state_t                  state_r;
    state_t                  state_next_s;
    logic [SEL_W-1:0]        sel_r;
    logic [SEL_W-1:0]        sel_next_s;
    logic [CNT_W-1:0]        cnt_r;
    logic                    accept_s;
    logic                    hs_s;
    logic                    s_ready_r;
    logic                    busy_r;
    logic                    done_r;
    logic [NUM_OF_BANKS-1:0] bank_full_r;
    logic                    bank_resetn_r [NUM_OF_BANKS-1:0];
    logic [BANK_SIZE-1:0]    bank_enable_r [NUM_OF_BANKS-1:0];
    logic [31:0]             bank_din_r    [NUM_OF_BANKS-1:0];

    // Next-state decode; outputs are registered from the next state so they align with it.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        hs_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && ({1'b0, bank_sel} < NUM_BANKS_W)) begin
                    accept_s     = 1'b1;
                    state_next_s = CLEAR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CLEAR: state_next_s = LOAD;
            LOAD: begin
                if (s_valid && s_ready_r) begin
                    hs_s = 1'b1;
                    if (cnt_r == LAST_WORD) begin
                        state_next_s = FLUSH;
                    end else begin
                        state_next_s = LOAD;
                    end
                end else begin
                    state_next_s = LOAD;
                end
            end
            FLUSH:   state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
        sel_next_s = accept_s ? bank_sel : sel_r;
    end

    // State, counter and all registered outputs; reset holds every bank in clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            sel_r       <= '0;
            cnt_r       <= '0;
            s_ready_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            bank_full_r <= '0;
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                bank_resetn_r[i] <= 1'b0;
                bank_enable_r[i] <= '0;
                bank_din_r[i]    <= 32'h0000_0000;
            end
        end else begin
            state_r   <= state_next_s;
            sel_r     <= sel_next_s;
            s_ready_r <= (state_next_s == LOAD);
            busy_r    <= (state_next_s != IDLE);
            done_r    <= (state_next_s == DONE);
            if (state_r == CLEAR) begin
                cnt_r <= '0;
            end else if (hs_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                bank_resetn_r[i] <= !((state_next_s == CLEAR) && (sel_next_s == SEL_W'(i)));
                if (hs_s && (sel_r == SEL_W'(i))) begin
                    bank_enable_r[i] <= ONE_HOT0 << cnt_r;
                    bank_din_r[i]    <= s_data;
                end else begin
                    bank_enable_r[i] <= '0;
                    bank_din_r[i]    <= 32'h0000_0000;
                end
                // The full flag drops when a reload is accepted and rises entering DONE.
                if (accept_s && (bank_sel == SEL_W'(i))) begin
                    bank_full_r[i] <= 1'b0;
                end else if ((state_next_s == DONE) && (sel_r == SEL_W'(i))) begin
                    bank_full_r[i] <= 1'b1;
                end else begin
                    bank_full_r[i] <= bank_full_r[i];
                end
            end
        end
    end

    assign s_ready     = s_ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign bank_full   = bank_full_r;
    assign bank_resetn = bank_resetn_r;
    assign bank_enable = bank_enable_r;
    assign bank_din    = bank_din_r;

endmodule

// File: tb/tb_bike_bank_loader.sv
// Directed bench for bike_bank_loader: default 4x8 instance plus a 3-bank instance
// for the out-of-range select case.
module tb_bike_bank_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  bank_sel;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        bank_resetn [3:0];
    logic [7:0]  bank_enable [3:0];
    logic [31:0] bank_din    [3:0];
    logic        busy;
    logic        done;
    logic [3:0]  bank_full;

    logic        start3;
    logic [1:0]  bank_sel3;
    logic        s_valid3;
    logic [31:0] s_data3;
    logic        s_ready3;
    logic        bank_resetn3 [2:0];
    logic [7:0]  bank_enable3 [2:0];
    logic [31:0] bank_din3    [2:0];
    logic        busy3;
    logic        done3;
    logic [2:0]  bank_full3;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_full = 4'b0000;

    bike_bank_loader #(.NUM_OF_BANKS(4), .BANK_SIZE(8)) dut (
        .clk(clk), .reset(reset), .start(start), .bank_sel(bank_sel),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .bank_resetn(bank_resetn), .bank_enable(bank_enable), .bank_din(bank_din),
        .busy(busy), .done(done), .bank_full(bank_full)
    );

    bike_bank_loader #(.NUM_OF_BANKS(3), .BANK_SIZE(8)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .bank_sel(bank_sel3),
        .s_valid(s_valid3), .s_data(s_data3), .s_ready(s_ready3),
        .bank_resetn(bank_resetn3), .bank_enable(bank_enable3), .bank_din(bank_din3),
        .busy(busy3), .done(done3), .bank_full(bank_full3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] pack_rn();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = bank_resetn[i];
        return r;
    endfunction

    function automatic bit any_enable_or_din();
        bit a = 1'b0;
        for (int i = 0; i < 4; i++) if (bank_enable[i] !== 8'h00 || bank_din[i] !== 32'h0) a = 1'b1;
        return a;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bank_sel = 2'd0; s_valid = 1'b0; s_data = 32'h0;
        start3 = 1'b0; bank_sel3 = 2'd0; s_valid3 = 1'b0; s_data3 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, s_ready} !== 3'b000) begin
            n_errors++; $display("FAIL reset_ctrl: busy/done/s_ready=%b expected 000", {busy, done, s_ready});
        end
        n_checks++;
        if (pack_rn() !== 4'b0000 || bank_full !== 4'b0000) begin
            n_errors++; $display("FAIL reset_banks: resetn=%b full=%b expected 0000/0000", pack_rn(), bank_full);
        end
        n_checks++;
        if (any_enable_or_din()) begin
            n_errors++; $display("FAIL reset_data: enable/din nonzero during reset, expected all zero");
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (pack_rn() !== 4'b1111 || busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_release: resetn=%b busy=%b expected 1111/0", pack_rn(), busy);
        end
    endtask

    task automatic test_load(input int sel, input bit gap, input bit poke);
        logic [3:0] m;
        int w;
        int cyc;
        bit v;
        bit bad;
        m = 4'b0001 << sel;
        start = 1'b1; bank_sel = 2'(sel);
        @(posedge clk); #1;
        start = 1'b0; bank_sel = 2'(sel ^ 1);
        n_checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0 || pack_rn() !== (4'b1111 & ~m) || bank_full !== (exp_full & ~m)) begin
            n_errors++;
            $display("FAIL clear_cycle: busy=%b s_ready=%b resetn=%b full=%b expected 1/0/%b/%b",
                     busy, s_ready, pack_rn(), bank_full, 4'b1111 & ~m, exp_full & ~m);
        end
        @(posedge clk); #1;
        n_checks++;
        if (s_ready !== 1'b1 || pack_rn() !== 4'b1111) begin
            n_errors++; $display("FAIL load_entry: s_ready=%b resetn=%b expected 1/1111", s_ready, pack_rn());
        end
        w = 0; cyc = 0;
        while (w < 8 && cyc < 40) begin
            v = gap ? (cyc % 2 == 1) : 1'b1;
            s_valid = v; s_data = 32'(w + 1);
            if (poke && w == 3) begin start = 1'b1; bank_sel = 2'd0; end
            else begin start = 1'b0; bank_sel = 2'(sel ^ 1); end
            @(posedge clk); #1;
            bad = 1'b0;
            for (int b = 0; b < 4; b++) begin
                if (b == sel && v) begin
                    if (bank_enable[b] !== (8'h01 << w) || bank_din[b] !== 32'(w + 1)) bad = 1'b1;
                end else if (bank_enable[b] !== 8'h00 || bank_din[b] !== 32'h0) bad = 1'b1;
            end
            n_checks++;
            if (bad) begin
                n_errors++;
                $display("FAIL load_word: word %0d valid %0b enable=%h din=%h expected %h/%h on bank %0d only",
                         w, v, bank_enable[sel], bank_din[sel], v ? (8'h01 << w) : 8'h00, v ? 32'(w + 1) : 32'h0, sel);
            end
            if (v) w++;
            n_checks++;
            if (s_ready !== (w < 8) || done !== 1'b0 || pack_rn() !== 4'b1111 || bank_full !== (exp_full & ~m) || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL load_ctrl: s_ready=%b done=%b resetn=%b full=%b busy=%b expected %b/0/1111/%b/1",
                         s_ready, done, pack_rn(), bank_full, busy, w < 8, exp_full & ~m);
            end
            cyc++;
        end
        start = 1'b0; s_valid = 1'b0;
        if (w < 8) begin
            n_checks++; n_errors++;
            $display("FAIL load_timeout: only %0d words accepted, expected 8", w);
        end
        exp_full = exp_full | m;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1 || bank_full !== exp_full || any_enable_or_din()) begin
            n_errors++; $display("FAIL done_pulse: done=%b full=%b expected 1/%b", done, bank_full, exp_full);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || bank_full !== exp_full) begin
            n_errors++; $display("FAIL back_idle: done=%b busy=%b full=%b expected 0/0/%b", done, busy, bank_full, exp_full);
        end
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1; bank_sel = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 32'(16 + i);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || pack_rn() !== 4'b0000 || bank_full !== 4'b0000 || any_enable_or_din()) begin
            n_errors++; $display("FAIL abort_reset: s_ready=%b busy=%b resetn=%b full=%b expected 0/0/0000/0000",
                                 s_ready, busy, pack_rn(), bank_full);
        end
        s_valid = 1'b0;
        exp_full = 4'b0000;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || pack_rn() !== 4'b1111) begin
                n_errors++; $display("FAIL abort_after: done=%b busy=%b resetn=%b expected 0/0/1111", done, busy, pack_rn());
            end
        end
    endtask

    task automatic test_bad_sel();
        start3 = 1'b1; bank_sel3 = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (busy3 !== 1'b0 || s_ready3 !== 1'b0 || bank_full3 !== 3'b000 || bank_resetn3[2] !== 1'b1) begin
                n_errors++; $display("FAIL bad_sel: busy=%b s_ready=%b full=%b expected 0/0/000", busy3, s_ready3, bank_full3);
            end
        end
        bank_sel3 = 2'd2;
        @(posedge clk); #1;
        start3 = 1'b0;
        n_checks++;
        if (busy3 !== 1'b1 || bank_resetn3[2] !== 1'b0) begin
            n_errors++; $display("FAIL good_sel3: busy=%b resetn2=%b expected 1/0", busy3, bank_resetn3[2]);
        end
    endtask

    initial begin
        test_reset();
        test_load(2, 1'b0, 1'b0);
        n_checks++;
        if (bank_full !== 4'b0100) begin
            n_errors++; $display("FAIL full_after_b2b: got %b expected 0100", bank_full);
        end
        test_load(2, 1'b1, 1'b0);
        test_load(3, 1'b0, 1'b1);
        n_checks++;
        if (bank_full !== 4'b1100) begin
            n_errors++; $display("FAIL full_after_poke: got %b expected 1100", bank_full);
        end
        test_reset();
        exp_full = 4'b0000;
        test_load(1, 1'b0, 1'b0);
        test_load(3, 1'b0, 1'b0);
        n_checks++;
        if (bank_full !== 4'b1010) begin
            n_errors++; $display("FAIL full_1_3: got %b expected 1010", bank_full);
        end
        test_load(1, 1'b1, 1'b0);
        test_reset_mid_load();
        test_bad_sel();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bike_bank_loader.md
BIKE_BANK_LOADER -- requirements
Module: bike_bank_loader

Interface
REQ-001 SHALL have parameter NUM_OF_BANKS, default 4: number of downstream register banks served.
REQ-002 SHALL have parameter BANK_SIZE, default 8: 32-bit words per bank (bank width BANK_SIZE*32).
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: reset is asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: request to load one bank.
REQ-006 SHALL have port bank_sel, input, $clog2(NUM_OF_BANKS) (min 1): target bank, sampled with start.
REQ-007 SHALL have port s_valid, input, 1: stream word valid.
REQ-008 SHALL have port s_data, input, 32: stream word.
REQ-009 SHALL have port s_ready, output, 1: stream word accepted when s_valid && s_ready.
REQ-010 SHALL have port bank_resetn, output, 1 x [NUM_OF_BANKS-1:0] unpacked: active-low clear per bank.
REQ-011 SHALL have port bank_enable, output, [BANK_SIZE-1:0] x [NUM_OF_BANKS-1:0] unpacked: per-word write enable.
REQ-012 SHALL have port bank_din, output, [31:0] x [NUM_OF_BANKS-1:0] unpacked: write data per bank.
REQ-013 SHALL have port busy, output, 1: high outside IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse, bank load complete.
REQ-015 SHALL have port bank_full, output, NUM_OF_BANKS: bank i holds a complete value.

Function
REQ-016 SHALL implement FSM IDLE, CLEAR, LOAD, FLUSH, DONE; reset state IDLE.
REQ-017 IDLE: start=1 with bank_sel<NUM_OF_BANKS SHALL latch sel, clear bank_full[sel], go CLEAR; start with bank_sel>=NUM_OF_BANKS SHALL be ignored.
REQ-018 CLEAR: exactly one cycle, bank_resetn[sel]=0 (registered), word counter=0, then LOAD.
REQ-019 LOAD: s_ready=1; other states s_ready=0.
REQ-020 On handshake in cycle t with counter k, cycle t+1 SHALL show bank_enable[sel]=one-hot bit k and bank_din[sel]=s_data of cycle t (registered, latency 1).
REQ-021 Counter SHALL increment per handshake only; s_valid gaps SHALL produce no enable and hold counter.
REQ-022 Handshake at k=BANK_SIZE-1 SHALL move to FLUSH (last enable visible), then DONE.
REQ-023 DONE: one cycle, done=1, bank_full[sel]=1 set, then IDLE.
REQ-024 At most one bit of any bank_enable, and only of bank sel, SHALL be high per cycle.
REQ-025 Non-selected banks SHALL see bank_enable=0, bank_din=0, bank_resetn=1.
REQ-026 start while busy SHALL be ignored; bank_sel changes after start acceptance SHALL have no effect.
REQ-027 bank_full bits of other banks SHALL be preserved across a load.
REQ-028 Reloading a full bank SHALL clear its bank_full at start acceptance and set it again at DONE.

Reset
REQ-029 reset=1 SHALL asynchronously force: state IDLE, counter 0, s_ready=0, busy=0, done=0, bank_full=0, all bank_enable=0, all bank_din=0, all bank_resetn=0.
REQ-030 bank_resetn SHALL return to all-ones on the first clock edge after reset deasserts.
REQ-031 reset mid-LOAD SHALL abort; partial bank contents are cleared via bank_resetn; no done pulse.

Verification
REQ-032 Defaults, reset released, start, bank_sel=2, 8 back-to-back words 0x1..0x8 -> CLEAR 1 cycle (bank_resetn[2]=0), enables bit0..bit7 on consecutive cycles with din 0x1..0x8, done pulse 2 cycles after last handshake, bank_full=4'b0100.
REQ-033 Same load with s_valid low every other cycle -> enables only on cycles after handshakes, identical data order, counter holds during gaps.
REQ-034 start pulsed during LOAD with bank_sel=0 -> ignored, bank 0 untouched, bank_full[0] unchanged.
REQ-035 Load bank 1 fully, then bank 3 -> bank_full=4'b1010; reload bank 1 -> bank_full[1]=0 from acceptance until DONE, then 1.
REQ-036 reset asserted after 3 words into bank 0 -> same-cycle s_ready=0, enables=0, bank_resetn=4'b0000, bank_full=0, no done.
REQ-037 NUM_OF_BANKS=3, start with bank_sel=3 -> no state change, busy stays 0.
